// File: rtl/fizzbuzz_pkg.sv
// -----------------------------------------------------------------------------
// fizzbuzz_pkg
// Shared types for the FizzBuzz sequence controller:
//   state_t   - controller states (IDLE, RUN, DONE)
//   fb_code_t - beat classification (FB_NONE, FB_FIZZ, FB_BUZZ, FB_FIZZBUZZ)
//   fb_classify() - packs the two divisibility flags into a fb_code_t
// Optional feature macro used by the controller: FIZZBUZZ_SEQ_STATS_EN.
// -----------------------------------------------------------------------------
package fizzbuzz_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   typedef enum logic [1:0] {
      FB_NONE     = 2'd0,
      FB_FIZZ     = 2'd1,
      FB_BUZZ     = 2'd2,
      FB_FIZZBUZZ = 2'd3
   } fb_code_t;

   // Bit 0 flags divisibility by FIZZ, bit 1 by BUZZ.
   function automatic fb_code_t fb_classify(input logic fizz_hit, input logic buzz_hit);
      return fb_code_t'({buzz_hit, fizz_hit});
   endfunction

endpackage

// File: rtl/fizzbuzz_residue.sv
// -----------------------------------------------------------------------------
// fizzbuzz_residue
// Tracks (value mod MOD) incrementally so no divider is needed.
// Ports:
//   clk      in  clock
//   resetn   in  asynchronous active-low reset (residue -> 0)
//   load_i   in  restart at value 1 (residue = 1, since MOD >= 2)
//   adv_i    in  value advanced by one; residue wraps at MOD-1
//   zero_o   out residue is zero, i.e. value divisible by MOD
// load_i has priority over adv_i.
// -----------------------------------------------------------------------------
module fizzbuzz_residue
   import fizzbuzz_pkg::*;
#(
   parameter int MOD = 3
) (
   input  logic clk,
   input  logic resetn,
   input  logic load_i,
   input  logic adv_i,
   output logic zero_o
);

   localparam int RW = $clog2(MOD);
   localparam logic [RW-1:0] LAST = RW'(MOD - 1);
   localparam logic [RW-1:0] ONE  = RW'(1);

   logic [RW-1:0] res_q;
   logic [RW-1:0] res_d;

   always_comb begin
      res_d = res_q;
      if (load_i) begin
         res_d = ONE;
      end else if (adv_i) begin
         res_d = (res_q == LAST) ? '0 : res_q + ONE;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         res_q <= '0;
      end else begin
         res_q <= res_d;
      end
   end

   assign zero_o = (res_q == '0);

endmodule

// File: rtl/fizzbuzz_seq_ctrl.sv
// -----------------------------------------------------------------------------
// fizzbuzz_seq_ctrl
// Emits the sequence 1..limit as valid/ready beats, each tagged with its
// FizzBuzz classification.
// Parameters: MAX_COUNT (largest value), FIZZ, BUZZ (divisors, >= 2).
// Ports:
//   clk        in   clock
//   resetn     in   asynchronous active-low reset
//   start      in   run request, sampled only in IDLE
//   limit      in   last sequence value, sampled with an accepted start
//   abort      in   abandon a running sequence (RUN/DONE) without done
//   out_ready  in   consumer ready
//   out_valid  out  beat valid (exactly in RUN)
//   out_value  out  current sequence value
//   out_code   out  0 none, 1 fizz, 2 buzz, 3 fizzbuzz
//   busy       out  state is not IDLE
//   done       out  one-cycle pulse on normal completion
// Optional (macro FIZZBUZZ_SEQ_STATS_EN):
//   fizz_cnt, buzz_cnt, fizzbuzz_cnt  out  transferred beats per code,
//   cleared on accepted start, held after done.
// -----------------------------------------------------------------------------
module fizzbuzz_seq_ctrl
   import fizzbuzz_pkg::*;
#(
   parameter  int MAX_COUNT = 255,
   parameter  int FIZZ      = 3,
   parameter  int BUZZ      = 5,
   localparam int CW        = $clog2(MAX_COUNT + 1)
) (
   input  logic          clk,
   input  logic          resetn,
   input  logic          start,
   input  logic [CW-1:0] limit,
   input  logic          abort,
   input  logic          out_ready,
   output logic          out_valid,
   output logic [CW-1:0] out_value,
   output logic [1:0]    out_code,
   output logic          busy,
   output logic          done
`ifdef FIZZBUZZ_SEQ_STATS_EN
   ,
   output logic [CW-1:0] fizz_cnt,
   output logic [CW-1:0] buzz_cnt,
   output logic [CW-1:0] fizzbuzz_cnt
`endif
);

   localparam logic [CW-1:0] MAX_CW = CW'(MAX_COUNT);
   localparam logic [CW-1:0] ONE    = CW'(1);

   state_t        state_q, state_d;
   logic [CW-1:0] value_q, value_d;
   logic [CW-1:0] limit_q, limit_d;
   logic [CW-1:0] limit_clamped;
   logic          accept;
   logic          hs;
   logic          res_load;
   logic          res_adv;
   logic          fizz_zero;
   logic          buzz_zero;
   fb_code_t      code;

   // limit can exceed MAX_COUNT when MAX_COUNT+1 is not a power of two.
   assign limit_clamped = (limit > MAX_CW) ? MAX_CW : limit;
   assign accept        = (state_q == IDLE) && start;
   assign hs            = (state_q == RUN) && out_ready;

   always_comb begin
      state_d  = state_q;
      value_d  = value_q;
      limit_d  = limit_q;
      res_load = 1'b0;
      res_adv  = 1'b0;
      case (state_q)
         IDLE: begin
            // abort is deliberately not looked at here
            if (start) begin
               limit_d  = limit_clamped;
               value_d  = ONE;
               res_load = 1'b1;
               state_d  = (limit_clamped == '0) ? DONE : RUN;
            end
         end
         RUN: begin
            if (hs) begin
               if (value_q == limit_q) begin
                  state_d = DONE;
               end else begin
                  value_d = value_q + ONE;
                  res_adv = 1'b1;
               end
            end
            // a beat handshaken in this cycle still counts as transferred
            if (abort) begin
               state_d = IDLE;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q <= IDLE;
         value_q <= '0;
         limit_q <= '0;
      end else begin
         state_q <= state_d;
         value_q <= value_d;
         limit_q <= limit_d;
      end
   end

   fizzbuzz_residue #(.MOD(FIZZ)) u_res_fizz (
      .clk    (clk),
      .resetn (resetn),
      .load_i (res_load),
      .adv_i  (res_adv),
      .zero_o (fizz_zero)
   );

   fizzbuzz_residue #(.MOD(BUZZ)) u_res_buzz (
      .clk    (clk),
      .resetn (resetn),
      .load_i (res_load),
      .adv_i  (res_adv),
      .zero_o (buzz_zero)
   );

   // Residues read zero while idle/reset, so gate the code to keep it 0 then.
   assign code      = (state_q == RUN) ? fb_classify(fizz_zero, buzz_zero) : FB_NONE;
   assign out_valid = (state_q == RUN);
   assign out_value = value_q;
   assign out_code  = code;
   assign busy      = (state_q != IDLE);
   // An abort arriving in DONE suppresses the completion pulse.
   assign done      = (state_q == DONE) && !abort;

`ifdef FIZZBUZZ_SEQ_STATS_EN
   logic [CW-1:0] fizz_cnt_q, fizz_cnt_d;
   logic [CW-1:0] buzz_cnt_q, buzz_cnt_d;
   logic [CW-1:0] fb_cnt_q,   fb_cnt_d;

   always_comb begin
      fizz_cnt_d = fizz_cnt_q;
      buzz_cnt_d = buzz_cnt_q;
      fb_cnt_d   = fb_cnt_q;
      if (accept) begin
         fizz_cnt_d = '0;
         buzz_cnt_d = '0;
         fb_cnt_d   = '0;
      end else if (hs) begin
         case (code)
            FB_FIZZ:     fizz_cnt_d = fizz_cnt_q + ONE;
            FB_BUZZ:     buzz_cnt_d = buzz_cnt_q + ONE;
            FB_FIZZBUZZ: fb_cnt_d   = fb_cnt_q + ONE;
            default:     ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         fizz_cnt_q <= '0;
         buzz_cnt_q <= '0;
         fb_cnt_q   <= '0;
      end else begin
         fizz_cnt_q <= fizz_cnt_d;
         buzz_cnt_q <= buzz_cnt_d;
         fb_cnt_q   <= fb_cnt_d;
      end
   end

   assign fizz_cnt     = fizz_cnt_q;
   assign buzz_cnt     = buzz_cnt_q;
   assign fizzbuzz_cnt = fb_cnt_q;
`endif

endmodule

// File: tb/tb_fizzbuzz_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_fizzbuzz_seq_ctrl
// Self-checking bench for fizzbuzz_seq_ctrl with default parameters.
// Expected beats come from plain modulo arithmetic on the sequence value.
// Define FIZZBUZZ_SEQ_STATS_EN to also check the statistics counters.
// -----------------------------------------------------------------------------
module tb_fizzbuzz_seq_ctrl;

   localparam int MAX_COUNT = 255;
   localparam int FIZZ      = 3;
   localparam int BUZZ      = 5;
   localparam int CW        = $clog2(MAX_COUNT + 1);

   logic          clk;
   logic          resetn;
   logic          start;
   logic [CW-1:0] limit;
   logic          abort;
   logic          out_ready;
   logic          out_valid;
   logic [CW-1:0] out_value;
   logic [1:0]    out_code;
   logic          busy;
   logic          done;
`ifdef FIZZBUZZ_SEQ_STATS_EN
   logic [CW-1:0] fizz_cnt;
   logic [CW-1:0] buzz_cnt;
   logic [CW-1:0] fizzbuzz_cnt;
`endif

   int errors = 0;
   int checks = 0;
   int m_fizz, m_buzz, m_fb;

   fizzbuzz_seq_ctrl #(
      .MAX_COUNT (MAX_COUNT),
      .FIZZ      (FIZZ),
      .BUZZ      (BUZZ)
   ) dut (
      .clk          (clk),
      .resetn       (resetn),
      .start        (start),
      .limit        (limit),
      .abort        (abort),
      .out_ready    (out_ready),
      .out_valid    (out_valid),
      .out_value    (out_value),
      .out_code     (out_code),
      .busy         (busy),
      .done         (done)
`ifdef FIZZBUZZ_SEQ_STATS_EN
      ,
      .fizz_cnt     (fizz_cnt),
      .buzz_cnt     (buzz_cnt),
      .fizzbuzz_cnt (fizzbuzz_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [1:0] fb_model(input int v);
      logic [1:0] c;
      c[0] = ((v % FIZZ) == 0);
      c[1] = ((v % BUZZ) == 0);
      return c;
   endfunction

   task automatic check_stats(input string tag);
`ifdef FIZZBUZZ_SEQ_STATS_EN
      checks++;
      if (fizz_cnt !== CW'(m_fizz) || buzz_cnt !== CW'(m_buzz) || fizzbuzz_cnt !== CW'(m_fb)) begin
         errors++;
         $display("FAIL stats_%s: got fizz=%0d buzz=%0d fb=%0d, want fizz=%0d buzz=%0d fb=%0d",
                  tag, fizz_cnt, buzz_cnt, fizzbuzz_cnt, m_fizz, m_buzz, m_fb);
      end
`else
      if (tag.len() < 0) $display("%s", tag);
`endif
   endtask

   // Starts one sequence and consumes it. ready_pct: chance of out_ready per
   // cycle; stall_beat/stall_len: force out_ready low on one beat; poke:
   // drive random start/limit while running; abort_beat: abort with that
   // beat's handshake (0 = never).
   task automatic run_seq(input int lim, input int ready_pct, input int stall_beat,
                          input int stall_len, input bit poke, input int abort_beat,
                          output int beats);
      int  eff, exp_v, stall_left, hold, budget, cyc;
      bit  aborted;
      eff = (lim > MAX_COUNT) ? MAX_COUNT : lim;
      m_fizz = 0; m_buzz = 0; m_fb = 0;
      beats = 0;
      start = 1'b1; limit = CW'(lim); abort = 1'b0; out_ready = 1'b0;
      @(posedge clk); #1;
      start = 1'b0; limit = CW'($urandom);
      if (eff == 0) begin
         #1;
         checks++;
         if (out_valid !== 1'b0 || done !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL zero_limit_done: got valid=%b done=%b busy=%b, want valid=0 done=1 busy=1",
                     out_valid, done, busy);
         end
         check_stats("zero");
         @(posedge clk); #1;
         checks++;
         if (busy !== 1'b0 || done !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL zero_limit_idle: got busy=%b done=%b valid=%b, want 0 0 0", busy, done, out_valid);
         end
         return;
      end
      exp_v = 1; stall_left = stall_len; hold = 0; aborted = 1'b0;
      budget = eff * 200 + stall_len + 20; cyc = 0;
      while (exp_v <= eff && !aborted) begin
         if (cyc >= budget) begin
            errors++; checks++;
            $display("FAIL seq_timeout: got no beat %0d within %0d cycles, want progress", exp_v, budget);
            out_ready = 1'b0; start = 1'b0; abort = 1'b0;
            return;
         end
         if (exp_v == stall_beat && stall_left > 0) begin
            out_ready = 1'b0; stall_left--;
         end else begin
            out_ready = ($urandom_range(99) < ready_pct);
         end
         abort = (exp_v == abort_beat) && out_ready;
         if (poke) begin
            start = 1'($urandom_range(1)); limit = CW'($urandom);
         end
         #1;
         checks++;
         if (out_valid !== 1'b1 || out_value !== CW'(exp_v) || out_code !== fb_model(exp_v)
             || busy !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL beat_%0d: got valid=%b value=%0d code=%0d busy=%b done=%b, want valid=1 value=%0d code=%0d busy=1 done=0",
                     exp_v, out_valid, out_value, out_code, busy, done, exp_v, fb_model(exp_v));
         end
         if (exp_v == stall_beat) hold++;
         if (out_ready) begin
            case (fb_model(exp_v))
               2'd1: m_fizz++;
               2'd2: m_buzz++;
               2'd3: m_fb++;
               default: ;
            endcase
            beats++;
            if (abort) aborted = 1'b1;
            exp_v++;
         end
         @(posedge clk); #1;
         cyc++;
      end
      out_ready = 1'b0; abort = 1'b0; start = 1'b0;
      if (stall_beat > 0 && stall_beat <= eff) begin
         checks++;
         if (hold != stall_len + 1) begin
            errors++;
            $display("FAIL stall_hold: got beat %0d shown %0d cycles, want %0d", stall_beat, hold, stall_len + 1);
         end
      end
      if (ready_pct == 100 && stall_len == 0 && !aborted) begin
         checks++;
         if (cyc != eff) begin
            errors++;
            $display("FAIL back_to_back: got %0d cycles for %0d beats, want %0d", cyc, eff, eff);
         end
      end
      #1;
      if (aborted) begin
         checks++;
         if (busy !== 1'b0 || out_valid !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL abort_idle: got busy=%b valid=%b done=%b, want 0 0 0", busy, out_valid, done);
         end
         check_stats("abort");
      end else begin
         checks++;
         if (done !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL done_pulse: got done=%b valid=%b busy=%b, want 1 0 1", done, out_valid, busy);
         end
         @(posedge clk); #1;
         checks++;
         if (done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_done: got done=%b busy=%b, want 0 0", done, busy);
         end
         check_stats("done");
      end
   endtask

   task automatic test_reset();
      resetn = 1'b1; start = 1'b0; limit = '0; abort = 1'b0; out_ready = 1'b0;
      #2 resetn = 1'b0;
      #1;
      checks++;
      if (out_valid !== 1'b0 || out_value !== '0 || out_code !== 2'd0 || busy !== 1'b0 || done !== 1'b0) begin
         errors++;
         $display("FAIL reset_state: got valid=%b value=%0d code=%0d busy=%b done=%b, want all 0",
                  out_valid, out_value, out_code, busy, done);
      end
      repeat (3) @(posedge clk);
      @(negedge clk) resetn = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (busy !== 1'b0 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_release_idle: got busy=%b valid=%b, want 0 0", busy, out_valid);
      end
   endtask

   task automatic test_limit15();
      int b;
      run_seq(15, 100, 0, 0, 1'b0, 0, b);
      checks++;
      if (b != 15) begin
         errors++;
         $display("FAIL limit15_beats: got %0d, want 15", b);
      end
   endtask

   task automatic test_backpressure();
      int b;
      run_seq(6, 100, 3, 3, 1'b0, 0, b);
      checks++;
      if (b != 6) begin
         errors++;
         $display("FAIL backpressure_beats: got %0d, want 6", b);
      end
   endtask

   task automatic test_zero_limit();
      int b;
      run_seq(0, 100, 0, 0, 1'b0, 0, b);
   endtask

   task automatic test_abort();
      int b;
      run_seq(10, 100, 0, 0, 1'b0, 4, b);
      checks++;
      if (b != 4) begin
         errors++;
         $display("FAIL abort_beats: got %0d, want 4", b);
      end
      run_seq(5, 100, 0, 0, 1'b0, 0, b);
      checks++;
      if (b != 5) begin
         errors++;
         $display("FAIL restart_after_abort: got %0d beats, want 5", b);
      end
   endtask

   task automatic test_reset_midrun();
      int n, b;
      start = 1'b1; limit = CW'(20);
      @(posedge clk); #1;
      start = 1'b0; out_ready = 1'b1;
      n = 0;
      while (out_value !== CW'(7) && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      checks++;
      if (out_value !== CW'(7) || out_valid !== 1'b1) begin
         errors++;
         $display("FAIL midrun_reach7: got value=%0d valid=%b, want 7 1", out_value, out_valid);
      end
      out_ready = 1'b0;
      #2 resetn = 1'b0;
      #1;
      checks++;
      if (out_valid !== 1'b0 || out_value !== '0 || out_code !== 2'd0 || busy !== 1'b0 || done !== 1'b0) begin
         errors++;
         $display("FAIL midrun_reset: got valid=%b value=%0d code=%0d busy=%b done=%b, want all 0",
                  out_valid, out_value, out_code, busy, done);
      end
      repeat (2) @(posedge clk);
      @(negedge clk) resetn = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (busy !== 1'b0 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL midrun_wait_idle: got busy=%b valid=%b, want 0 0", busy, out_valid);
      end
      // start/limit toggled while running must not disturb the sequence
      run_seq(12, 70, 0, 0, 1'b1, 0, b);
      checks++;
      if (b != 12) begin
         errors++;
         $display("FAIL start_ignored_beats: got %0d, want 12", b);
      end
   endtask

   task automatic test_random();
      int b, lim;
      for (int i = 0; i < 12; i++) begin
         lim = $urandom_range(40);
         run_seq(lim, $urandom_range(100, 30), 0, 0, 1'($urandom_range(1)), 0, b);
         checks++;
         if (b != lim) begin
            errors++;
            $display("FAIL random_%0d_beats: got %0d, want %0d", i, b, lim);
         end
      end
   endtask

   task automatic test_stats30();
      int b;
      run_seq(30, 100, 0, 0, 1'b0, 0, b);
`ifdef FIZZBUZZ_SEQ_STATS_EN
      checks++;
      if (fizz_cnt !== CW'(8) || buzz_cnt !== CW'(4) || fizzbuzz_cnt !== CW'(2)) begin
         errors++;
         $display("FAIL stats30: got fizz=%0d buzz=%0d fb=%0d, want 8 4 2", fizz_cnt, buzz_cnt, fizzbuzz_cnt);
      end
`endif
      checks++;
      if (b != 30) begin
         errors++;
         $display("FAIL limit30_beats: got %0d, want 30", b);
      end
   endtask

   initial begin
      test_reset();
      test_limit15();
      test_backpressure();
      test_zero_limit();
      test_abort();
      test_reset_midrun();
      test_random();
      test_stats30();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
